toggle_pulse_gen: RTL and testbench
===================================

TOGGLE_PULSE_GEN -- requirements
Module: toggle_pulse_gen

Interface
REQ-001 Parameter: DB_CYCLES, default 16, debounce window in clk cycles; legal range 2..65535.
REQ-002 Parameter: HOLD_CYCLES, default 32, held-time before the first auto-repeat pulse; legal range 2..65535.
REQ-003 Parameter: REPEAT_CYCLES, default 8, period between auto-repeat pulses; legal range 2..65535.
REQ-004 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-005 Port: reset  input  1  synchronous, active-high reset.
REQ-006 Port: btn_in  input  1  raw, asynchronous, bouncing switch level.
REQ-007 Port: t  output  1  registered single-cycle toggle pulse; drives the t input of the downstream toggle flip-flop stage.
REQ-008 Port: pressed  output  1  registered debounced switch level.
REQ-009 Port: press_cnt  output  8  registered count of emitted t pulses.

Function
REQ-010 btn_in SHALL pass through a two-flop synchronizer; its second stage (btn_s) SHALL be the only btn_in-derived signal used by the FSM.
REQ-011 FSM states SHALL be IDLE, PRESS_DB, HELD and REL_DB; one 16-bit counter cnt SHALL be shared by all states.
REQ-012 In IDLE with btn_s=1, the FSM SHALL go to PRESS_DB and clear cnt.
REQ-013 In PRESS_DB with btn_s=0, the FSM SHALL return to IDLE with no pulse (glitch rejected).
REQ-014 In PRESS_DB, cnt SHALL increment each cycle; with cnt==DB_CYCLES-1 and btn_s=1, the FSM SHALL go to HELD, set pressed=1, pulse t and clear cnt.
REQ-015 In HELD with btn_s=0, the FSM SHALL go to REL_DB and clear cnt.
REQ-016 In REL_DB with btn_s=1, the FSM SHALL return to HELD with no pulse; pressed stays 1.
REQ-017 In REL_DB with cnt==DB_CYCLES-1 and btn_s=0, the FSM SHALL go to IDLE and clear pressed.
REQ-018 Latency: if btn_in is first sampled high at edge N and held clean, t SHALL be 1 for exactly the cycle following edge N+DB_CYCLES+2.
REQ-019 t SHALL never be high for two consecutive cycles.
REQ-020 press_cnt SHALL increment on every t pulse and wrap 255->0.
REQ-021 pressed SHALL deassert no earlier than DB_CYCLES+2 edges after btn_in falls cleanly.

Reset
REQ-022 With reset=1 at an edge: state=IDLE, cnt=0, both synchronizer flops=0, t=0, pressed=0, press_cnt=0.
REQ-023 Reset SHALL take priority over every FSM transition; a pulse due in the same cycle SHALL be suppressed.
REQ-024 A switch still held when reset is released SHALL be treated as a new press: full debounce, then one pulse.

Configuration
REQ-025 Macro AUTO_REPEAT_EN SHALL, when defined, enable auto-repeat.
REQ-026 With AUTO_REPEAT_EN, in HELD:
- cnt counts while btn_s=1.
- First repeat pulse after HOLD_CYCLES cycles in HELD.
- Further pulses every REPEAT_CYCLES cycles.
- Each pulse increments press_cnt.
- Leaving HELD stops repeat; re-entering HELD from REL_DB restarts the HOLD_CYCLES wait.
REQ-027 Without AUTO_REPEAT_EN, no repeat logic SHALL be compiled; exactly one t pulse per debounced press; HOLD_CYCLES and REPEAT_CYCLES are unused.

Verification
REQ-028 Clean press: DB_CYCLES=4, btn_in 0->1 sampled at edge 10 and held -> t=1 only after edge 16, pressed=1 from edge 16, press_cnt=1.
REQ-029 Bounce: DB_CYCLES=4, btn_in high for 3 cycles then low -> t never asserts, pressed=0, press_cnt=0.
REQ-030 Release bounce: while HELD, btn_in low 2 cycles then high -> pressed stays 1, no extra t pulse.
REQ-031 Reset mid-debounce: reset asserted one edge before the expected pulse -> t=0, all outputs 0; btn_in still high -> pulse DB_CYCLES+2 edges after reset release.
REQ-032 Wrap: 256 clean presses -> press_cnt returns to 0 and exactly 256 single-cycle t pulses are seen.
REQ-033 AUTO_REPEAT_EN with DB_CYCLES=4, HOLD_CYCLES=32, REPEAT_CYCLES=8; btn_in held 60 cycles after the first pulse -> pulses at first+32, +40, +48, +56; press_cnt=5.

Source files
------------

// File: rtl/toggle_pulse_gen.sv
// toggle_pulse_gen
//   Debounces a raw push-button and emits a single-cycle toggle pulse per
//   debounced press, intended for the t input of a downstream toggle flop.
//   An optional auto-repeat mode is compiled in when the macro
//   AUTO_REPEAT_EN is defined. It then produces further pulses while the
//   button stays held.
//
// Parameters
//   DB_CYCLES     debounce window in clk cycles (2..65535)
//   HOLD_CYCLES   held time before the first auto-repeat pulse (2..65535)
//   REPEAT_CYCLES period between auto-repeat pulses (2..65535)
//
// Ports
//   clk        in   single clock, rising edge
//   reset      in   synchronous, active-high reset
//   btn_in     in   raw asynchronous switch level
//   t          out  registered single-cycle toggle pulse
//   pressed    out  registered debounced switch level
//   press_cnt  out  registered 8-bit count of emitted t pulses (wraps)
module toggle_pulse_gen #(
  parameter int DB_CYCLES     = 16,
  parameter int HOLD_CYCLES   = 32,
  parameter int REPEAT_CYCLES = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_in,
  output logic       t,
  output logic       pressed,
  output logic [7:0] press_cnt
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PRESS_DB = 2'd1,
    HELD     = 2'd2,
    REL_DB   = 2'd3
  } state_t;

  localparam bool_params_ok =
    (DB_CYCLES     >= 2) && (DB_CYCLES     <= 65535) &&
    (HOLD_CYCLES   >= 2) && (HOLD_CYCLES   <= 65535) &&
    (REPEAT_CYCLES >= 2) && (REPEAT_CYCLES <= 65535);

  if (!bool_params_ok) begin : g_bad_params
    $error("toggle_pulse_gen: cycle parameters must lie in 2..65535");
  end

  localparam logic [15:0] DB_LAST = 16'(DB_CYCLES - 1);

  state_t      state, state_nxt;
  logic [15:0] cnt, cnt_nxt;
  logic        sync1, btn_s;
  logic        t_nxt, pressed_nxt;

`ifdef AUTO_REPEAT_EN
  localparam logic [15:0] HOLD_LAST = 16'(HOLD_CYCLES - 1);
  localparam logic [15:0] REP_LAST  = 16'(REPEAT_CYCLES - 1);

  // Set after the first repeat pulse so the shared counter switches from the
  // initial hold wait to the shorter repeat period.
  logic        rep, rep_nxt;
  logic [15:0] rep_last;

  assign rep_last = rep ? REP_LAST : HOLD_LAST;
`endif

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    t_nxt       = 1'b0;
    pressed_nxt = pressed;
`ifdef AUTO_REPEAT_EN
    rep_nxt     = rep;
`endif
    case (state)
      IDLE: begin
        if (btn_s) begin
          state_nxt = PRESS_DB;
          cnt_nxt   = '0;
        end
      end
      PRESS_DB: begin
        if (!btn_s) begin
          // Glitch shorter than the debounce window: drop it silently.
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else if (cnt == DB_LAST) begin
          state_nxt   = HELD;
          pressed_nxt = 1'b1;
          t_nxt       = 1'b1;
          cnt_nxt     = '0;
`ifdef AUTO_REPEAT_EN
          rep_nxt     = 1'b0;
`endif
        end else begin
          cnt_nxt = cnt + 16'd1;
        end
      end
      HELD: begin
        if (!btn_s) begin
          state_nxt = REL_DB;
          cnt_nxt   = '0;
`ifdef AUTO_REPEAT_EN
          rep_nxt   = 1'b0;
        end else if (cnt == rep_last) begin
          t_nxt   = 1'b1;
          cnt_nxt = '0;
          rep_nxt = 1'b1;
        end else begin
          cnt_nxt = cnt + 16'd1;
`endif
        end
      end
      REL_DB: begin
        if (btn_s) begin
          // Release bounce: back to HELD, no new pulse, hold wait restarts.
          state_nxt = HELD;
          cnt_nxt   = '0;
`ifdef AUTO_REPEAT_EN
          rep_nxt   = 1'b0;
`endif
        end else if (cnt == DB_LAST) begin
          state_nxt   = IDLE;
          pressed_nxt = 1'b0;
          cnt_nxt     = '0;
        end else begin
          cnt_nxt = cnt + 16'd1;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Reset wins over every transition, so a pulse due this edge is dropped.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1     <= 1'b0;
      btn_s     <= 1'b0;
      state     <= IDLE;
      cnt       <= '0;
      t         <= 1'b0;
      pressed   <= 1'b0;
      press_cnt <= '0;
`ifdef AUTO_REPEAT_EN
      rep       <= 1'b0;
`endif
    end else begin
      sync1   <= btn_in;
      btn_s   <= sync1;
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      t       <= t_nxt;
      pressed <= pressed_nxt;
      if (t_nxt) begin
        press_cnt <= press_cnt + 8'd1;
      end
`ifdef AUTO_REPEAT_EN
      rep     <= rep_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_toggle_pulse_gen.sv
module tb_toggle_pulse_gen;

  logic       clk;
  logic       reset;
  logic       btn_in;
  logic       t;
  logic       pressed;
  logic [7:0] press_cnt;

  int compared;
  int mismatched;
  int tcount;
  int dbl;
  int t0;
  logic prev_t;

  toggle_pulse_gen #(
    .DB_CYCLES    (4),
    .HOLD_CYCLES  (32),
    .REPEAT_CYCLES(8)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .btn_in   (btn_in),
    .t        (t),
    .pressed  (pressed),
    .press_cnt(press_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse monitor sampled on the falling edge.
  initial begin
    tcount = 0;
    dbl    = 0;
    prev_t = 1'b0;
  end
  always @(negedge clk) begin
    if (t === 1'b1) tcount++;
    if (t === 1'b1 && prev_t === 1'b1) dbl++;
    prev_t = t;
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    reset      = 1'b1;
    btn_in     = 1'b0;
    cyc(3);
    check("reset_t", 32'(t), 0);
    check("reset_pressed", 32'(pressed), 0);
    check("reset_press_cnt", 32'(press_cnt), 0);
    reset = 1'b0;
    cyc(2);

    // Clean press: first sampled at edge N, pulse after edge N+6.
    btn_in = 1'b1;
    for (int i = 0; i < 6; i++) begin
      cyc(1);
      check("clean_t_early", 32'(t), 0);
    end
    check("clean_pressed_early", 32'(pressed), 0);
    cyc(1);
    check("clean_t_pulse", 32'(t), 1);
    check("clean_pressed", 32'(pressed), 1);
    check("clean_press_cnt", 32'(press_cnt), 1);
    cyc(1);
    check("clean_t_single", 32'(t), 0);
    cyc(1);

    // Release bounce: low for two cycles then high again.
    btn_in = 1'b0;
    cyc(2);
    btn_in = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cyc(1);
      check("relbounce_pressed", 32'(pressed), 1);
      check("relbounce_t", 32'(t), 0);
    end
    check("relbounce_press_cnt", 32'(press_cnt), 1);

    // Clean release: pressed drops after edge M+6.
    btn_in = 1'b0;
    cyc(6);
    check("release_pressed_hold", 32'(pressed), 1);
    cyc(1);
    check("release_pressed_low", 32'(pressed), 0);
    cyc(3);

    // Press bounce: three cycles high then low, never debounced.
    btn_in = 1'b1;
    cyc(3);
    btn_in = 1'b0;
    for (int i = 0; i < 12; i++) begin
      cyc(1);
      check("bounce_t", 32'(t), 0);
    end
    check("bounce_pressed", 32'(pressed), 0);
    check("bounce_press_cnt", 32'(press_cnt), 1);

    // Reset on the edge where the pulse is due, switch still held.
    btn_in = 1'b1;
    cyc(6);
    check("rstmid_t_before", 32'(t), 0);
    reset = 1'b1;
    cyc(1);
    check("rstmid_t", 32'(t), 0);
    check("rstmid_pressed", 32'(pressed), 0);
    check("rstmid_press_cnt", 32'(press_cnt), 0);
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      cyc(1);
      check("rstmid_t_wait", 32'(t), 0);
    end
    cyc(1);
    check("rstmid_t_pulse", 32'(t), 1);
    check("rstmid_press_cnt_after", 32'(press_cnt), 1);
    btn_in = 1'b0;
    cyc(10);
    check("rstmid_released", 32'(pressed), 0);

    // Wrap: 256 clean presses from a fresh reset.
    reset = 1'b1;
    cyc(2);
    reset = 1'b0;
    check("wrap_start", 32'(press_cnt), 0);
    t0 = tcount;
    for (int p = 0; p < 256; p++) begin
      btn_in = 1'b1;
      cyc(10);
      btn_in = 1'b0;
      cyc(10);
      if (p == 254) check("wrap_255", 32'(press_cnt), 255);
    end
    check("wrap_press_cnt", 32'(press_cnt), 0);
    check("wrap_pulses", 32'(tcount - t0), 256);
    check("no_double_pulse", 32'(dbl), 0);

`ifdef AUTO_REPEAT_EN
    // Auto-repeat: held 60 cycles after the first pulse.
    btn_in = 1'b1;
    cyc(7);
    check("rep_first", 32'(t), 1);
    for (int k = 1; k < 64; k++) begin
      cyc(1);
      check("rep_t", 32'(t),
            (k == 32 || k == 40 || k == 48 || k == 56) ? 32'd1 : 32'd0);
      if (k == 60) btn_in = 1'b0;
    end
    check("rep_press_cnt", 32'(press_cnt), 5);
    cyc(10);
    check("rep_released", 32'(pressed), 0);
    check("rep_no_double", 32'(dbl), 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
